// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam int MD_LATENCY_DEF = 4;
  localparam int MD_CNT_W       = 4;

endpackage

// File: rtl/hazard_md_timer.sv
// Down-counter that times the multiply/divide stall; parks at zero once expired.
module hazard_md_timer
  import hazard_pkg::*;
#(
  parameter logic [MD_CNT_W-1:0] LOAD_VALUE = MD_CNT_W'(MD_LATENCY_DEF - 2)
) (
  input  logic                reloj,
  input  logic                reset,
  input  logic                load,
  output logic [MD_CNT_W-1:0] value,
  output logic                zero
);

  assign zero = (value == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge reloj) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= LOAD_VALUE;
    end else if (!zero) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, branch flushes, multi-cycle MD stalls
// and a saturating stall statistics counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY  = MD_LATENCY_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic [4:0]             rs_id,
  input  logic [4:0]             rt_id,
  input  logic [4:0]             rt_ex,
  input  logic                   memread_ex,
  input  logic                   branch_taken,
  input  logic                   md_start,
  output logic                   enablePC,
  output logic                   enableIF,
  output logic                   resetIF,
  output logic                   enableID,
  output logic                   resetID,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 2);

  state_t              state, state_next;
  logic                md_load;
  logic                md_zero;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                load_use;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = memread_ex && (rt_ex != 5'd0) &&
                    ((rt_ex == rs_id) || (rt_ex == rt_id));

  hazard_md_timer #(
    .LOAD_VALUE (MD_LOAD)
  ) u_md_timer (
    .reloj (reloj),
    .reset (reset),
    .load  (md_load),
    .value (md_cnt),
    .zero  (md_zero)
  );

  always_ff @(posedge reloj) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    md_load    = 1'b0;
    enablePC   = 1'b1;
    enableIF   = 1'b1;
    enableID   = 1'b1;
    resetIF    = 1'b0;
    resetID    = 1'b0;
    busy       = 1'b0;

    if (reset) begin
      enablePC = 1'b0;
      enableIF = 1'b0;
      enableID = 1'b0;
      resetIF  = 1'b1;
      resetID  = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            // Taken branch squashes both younger stages, including any MD start.
            resetIF = 1'b1;
            resetID = 1'b1;
          end else begin
            if (load_use) begin
              enablePC = 1'b0;
              enableIF = 1'b0;
              resetID  = 1'b1;
            end
            if (md_start) begin
              md_load    = 1'b1;
              state_next = MD_BUSY;
            end
          end
        end
        MD_BUSY: begin
          enablePC = 1'b0;
          enableIF = 1'b0;
          enableID = 1'b0;
          busy     = 1'b1;
          if (md_zero) begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!enablePC && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push expectations, a monitor checks them.
module tb_hazard_unit;

  // Expected control bits, ordered {enablePC, enableIF, resetIF, enableID, resetID, busy}
  localparam logic [5:0] C_RST = 6'b001010;
  localparam logic [5:0] C_RUN = 6'b110100;
  localparam logic [5:0] C_LU  = 6'b000110;
  localparam logic [5:0] C_BR  = 6'b111110;
  localparam logic [5:0] C_MD  = 6'b000001;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [15:0] sc;
    logic [3:0]  sc4;
  } exp_t;

  logic        reloj = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs_id = '0, rt_id = '0, rt_ex = '0;
  logic        memread_ex = 1'b0, branch_taken = 1'b0, md_start = 1'b0;

  logic        pc_a, if_a, rif_a, id_a, rid_a, busy_a;
  logic [15:0] sc_a;
  logic        pc_b, if_b, rif_b, id_b, rid_b, busy_b;
  logic [3:0]  sc_b;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;
  logic [15:0] model_sc  = '0;
  logic [3:0]  model_sc4 = '0;

  always #5 reloj = ~reloj;

  hazard_unit #(.MD_LATENCY(4), .STALL_CNT_W(16)) dut_a (
    .reloj(reloj), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .rt_ex(rt_ex),
    .memread_ex(memread_ex), .branch_taken(branch_taken), .md_start(md_start),
    .enablePC(pc_a), .enableIF(if_a), .resetIF(rif_a), .enableID(id_a),
    .resetID(rid_a), .busy(busy_a), .stall_count(sc_a)
  );

  hazard_unit #(.MD_LATENCY(4), .STALL_CNT_W(4)) dut_b (
    .reloj(reloj), .reset(reset), .rs_id(rs_id), .rt_id(rt_id), .rt_ex(rt_ex),
    .memread_ex(memread_ex), .branch_taken(branch_taken), .md_start(md_start),
    .enablePC(pc_b), .enableIF(if_b), .resetIF(rif_b), .enableID(id_b),
    .resetID(rid_b), .busy(busy_b), .stall_count(sc_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the response expected during that cycle.
  task automatic vec(input string name, input logic rst, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rte, input logic mr,
                     input logic br, input logic md, input logic [5:0] ctrl);
    exp_t e;
    @(posedge reloj);
    #1;
    reset        = rst;
    rs_id        = rs;
    rt_id        = rt;
    rt_ex        = rte;
    memread_ex   = mr;
    branch_taken = br;
    md_start     = md;
    e.ctrl = ctrl;
    e.sc   = model_sc;
    e.sc4  = model_sc4;
    exp_q.push_back(e);
    name_q.push_back(name);
    if (rst) begin
      model_sc  = '0;
      model_sc4 = '0;
    end else if (!ctrl[5]) begin
      if (model_sc != 16'hFFFF) model_sc = model_sc + 1'b1;
      if (model_sc4 != 4'hF)    model_sc4 = model_sc4 + 1'b1;
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge reloj);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check({n, " ctrl_a"}, 32'({pc_a, if_a, rif_a, id_a, rid_a, busy_a}), 32'(e.ctrl));
        check({n, " sc_a"},   32'(sc_a), 32'(e.sc));
        check({n, " ctrl_b"}, 32'({pc_b, if_b, rif_b, id_b, rid_b, busy_b}), 32'(e.ctrl));
        check({n, " sc_b"},   32'(sc_b), 32'(e.sc4));
      end
    end
  end

  initial begin
    int waited;
    // Reset state
    vec("reset0", 1, 0, 0, 0, 0, 0, 0, C_RST);
    vec("reset1", 1, 0, 0, 0, 0, 0, 0, C_RST);
    vec("idle",   0, 0, 0, 0, 0, 0, 0, C_RUN);
    // Load-use and its non-hazard neighbours
    vec("lu_rs",     0, 5, 0, 5, 1, 0, 0, C_LU);
    vec("after_lu",  0, 0, 0, 0, 0, 0, 0, C_RUN);
    vec("lu_rt",     0, 3, 7, 7, 1, 0, 0, C_LU);
    vec("zero_reg",  0, 0, 0, 0, 1, 0, 0, C_RUN);
    vec("no_memrd",  0, 5, 0, 5, 0, 0, 0, C_RUN);
    vec("no_match",  0, 3, 4, 5, 1, 0, 0, C_RUN);
    // Branch priority over load-use, then branch alone
    vec("br_lu",     0, 5, 0, 5, 1, 1, 0, C_BR);
    vec("br_only",   0, 0, 0, 0, 0, 1, 0, C_BR);
    // MD stall of 3 cycles with noise that must be ignored
    vec("md_start",  0, 0, 0, 0, 0, 0, 1, C_RUN);
    vec("md_busy1",  0, 5, 0, 5, 1, 0, 0, C_MD);
    vec("md_busy2",  0, 0, 0, 0, 0, 1, 0, C_MD);
    vec("md_busy3",  0, 0, 0, 0, 0, 0, 1, C_MD);
    vec("md_done",   0, 0, 0, 0, 0, 0, 0, C_RUN);
    // MD start together with load-use: bubble now, stall still follows
    vec("md_lu",     0, 9, 0, 9, 1, 0, 1, C_LU);
    vec("md_lu_b1",  0, 0, 0, 0, 0, 0, 0, C_MD);
    vec("md_lu_b2",  0, 0, 0, 0, 0, 0, 0, C_MD);
    vec("md_lu_b3",  0, 0, 0, 0, 0, 0, 0, C_MD);
    vec("md_lu_end", 0, 0, 0, 0, 0, 0, 0, C_RUN);
    // Branch cancels an MD start
    vec("md_br",     0, 0, 0, 0, 0, 1, 1, C_BR);
    vec("md_br_nxt", 0, 0, 0, 0, 0, 0, 0, C_RUN);
    // Reset in the 2nd MD cycle aborts the stall
    vec("md_rst_s",  0, 0, 0, 0, 0, 0, 1, C_RUN);
    vec("md_rst_b1", 0, 0, 0, 0, 0, 0, 0, C_MD);
    vec("md_rst",    1, 0, 0, 0, 0, 0, 0, C_RST);
    vec("post_rst1", 0, 0, 0, 0, 0, 0, 0, C_RUN);
    vec("post_rst2", 0, 0, 0, 0, 0, 0, 0, C_RUN);
    // 20 consecutive stalls: the 4-bit counter must stick at 15
    for (int i = 0; i < 20; i++) vec($sformatf("sat%0d", i), 0, 6, 0, 6, 1, 0, 0, C_LU);
    vec("sat_hold",  0, 0, 0, 0, 0, 0, 0, C_RUN);
    vec("sat_hold2", 0, 0, 0, 0, 0, 0, 0, C_RUN);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge reloj);
      waited++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4: EX-stage cycles of a multiply/divide op (legal range 2..15).
REQ-002 SHALL have parameter STALL_CNT_W, default 16: width of the stall statistics counter.
REQ-003 SHALL have port reloj, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rs_id, input, 5: rs field of the instruction in ID.
REQ-006 SHALL have port rt_id, input, 5: rt field of the instruction in ID.
REQ-007 SHALL have port rt_ex, input, 5: rt_o from the ID/EX register (load destination).
REQ-008 SHALL have port memread_ex, input, 1: the instruction in EX is a load.
REQ-009 SHALL have port branch_taken, input, 1: branch/jump resolved taken in EX.
REQ-010 SHALL have port md_start, input, 1: multiply/divide entered EX this cycle.
REQ-011 SHALL have port enablePC, output, 1: PC write enable.
REQ-012 SHALL have port enableIF, output, 1: IF/ID register enable.
REQ-013 SHALL have port resetIF, output, 1: IF/ID flush, synchronous.
REQ-014 SHALL have port enableID, output, 1: ID/EX register enable.
REQ-015 SHALL have port resetID, output, 1: ID/EX flush (bubble insert), synchronous.
REQ-016 SHALL have port busy, output, 1: multi-cycle stall in progress.
REQ-017 SHALL have port stall_count, output, STALL_CNT_W: saturating count of cycles with enablePC=0 outside reset.

Function
REQ-018 SHALL implement states RUN and MD_BUSY, plus a 4-bit down-counter md_cnt.
REQ-019 Outputs SHALL be combinational from state and current inputs; only the state, md_cnt and stall_count SHALL be registered.
REQ-020 RUN, no event: enablePC=enableIF=enableID=1, resetIF=resetID=0, busy=0.
REQ-021 Load-use hazard SHALL be: memread_ex=1, rt_ex!=0, and (rt_ex==rs_id or rt_ex==rt_id).
REQ-022 RUN with a load-use hazard: enablePC=0, enableIF=0, resetID=1, enableID=1; exactly one bubble per hazard cycle, with no state change.
REQ-023 RUN with branch_taken=1: resetIF=1, resetID=1, enablePC=1; this SHALL override the load-use response in the same cycle.
REQ-024 RUN with md_start=1 and branch_taken=0: outputs as REQ-020 this cycle; next state MD_BUSY with md_cnt=MD_LATENCY-2.
REQ-025 MD_BUSY: enablePC=enableIF=enableID=0, resets 0, busy=1; md_cnt decrements each cycle.
REQ-026 MD_BUSY with md_cnt==0: the next state SHALL be RUN, giving exactly MD_LATENCY-1 stall cycles.
REQ-027 In MD_BUSY, md_start, branch_taken and memread_ex SHALL be ignored.
REQ-028 When md_start and a load-use hazard occur together, load-use SHALL apply this cycle and the MD transition SHALL still occur.
REQ-029 stall_count SHALL increment each cycle enablePC=0 and reset=0, and SHALL saturate at all-ones without wrapping.

Reset
REQ-030 While reset=1: enablePC=enableIF=enableID=0, resetIF=resetID=1, busy=0.
REQ-031 On a clock edge with reset=1: state SHALL be RUN, md_cnt 0, stall_count 0.
REQ-032 Reset asserted during MD_BUSY SHALL abort the stall; the first cycle after reset deasserts SHALL be RUN.

Structure
REQ-033 State encoding and MD_LATENCY default SHALL live in shared package hazard_pkg.
REQ-034 md_cnt load/decrement/zero-detect SHALL be sub-module hazard_md_timer (load, value, zero); the rest SHALL stay in hazard_unit.

Verification
REQ-035 Load-use bench: memread_ex=1, rt_ex=5, rs_id=5 for one cycle -> enablePC=0, enableIF=0, resetID=1 that cycle; stall_count 0->1.
REQ-036 Zero-register bench: memread_ex=1, rt_ex=0, rs_id=0 -> RUN outputs, no bubble.
REQ-037 Branch-priority bench: branch_taken=1 plus a load-use hazard -> resetIF=1, resetID=1, enablePC=1.
REQ-038 MD bench: MD_LATENCY=4, md_start pulse -> busy=1 and enables 0 for exactly 3 cycles, then RUN; branch_taken pulsed mid-stall ignored.
REQ-039 Reset bench: reset pulsed in the 2nd MD_BUSY cycle -> the next cycle after release is RUN, stall_count=0.
REQ-040 Saturation bench: STALL_CNT_W=4, 20 stall cycles -> stall_count holds 15.
